// File: rtl/mem_io_responder.sv
// Responder end of the byte-serial memory bus: one-byte RAM accesses plus a
// small IO window holding the UART TX FIFO, the RX holding byte, a status
// register and a halt strobe.
module mem_io_responder #(
  parameter int ADDR_W      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        halt_out,
  output logic        overflow
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage
  logic [7:0]        ram      [0:(1<<ADDR_W)-1];
  logic [7:0]        fifo_mem [0:TX_DEPTH-1];
  logic [7:0]        rx_byte;
  logic              rx_full;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  // Address decode
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       io_off;
  logic              is_io;
  logic              unused_addr_bits;

  // Access qualifiers
  logic              ram_we;
  logic              rd_en;
  logic              tx_push_req;
  logic              tx_pop;
  logic              tx_full;
  logic              push_ok;
  logic              push_drop;
  logic              rx_pop;
  logic              rx_overrun;
  logic              halt_req;
  logic [7:0]        io_rd;
  logic [7:0]        rd_byte;

  assign ram_idx          = mem_a[ADDR_W-1:0];
  assign io_off           = mem_a[15:0];
  assign is_io            = (mem_a[17:16] == 2'b11);
  assign unused_addr_bits = ^mem_a[31:18];

  assign ram_we      = rdy_in && mem_wr && !is_io;
  assign rd_en       = rdy_in && !mem_wr;
  assign tx_push_req = rdy_in && mem_wr && is_io && (io_off == 16'h0000);
  assign halt_req    = rdy_in && mem_wr && is_io && (io_off == 16'h0004);
  assign rx_pop      = rd_en && is_io && (io_off == 16'h0000) && rx_full;
  assign rx_overrun  = rx_valid && rx_full && !rx_pop;

  // TX FIFO head is presented combinationally; zero when empty
  assign tx_valid   = (count != '0);
  assign tx_data    = tx_valid ? fifo_mem[head] : 8'h00;
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_full    = (count == CNT_W'(TX_DEPTH));
  assign push_ok    = tx_push_req && (!tx_full || tx_pop);
  assign push_drop  = tx_push_req && tx_full && !tx_pop;
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(tx_pop);

  // IO read mux; RX data reads 0x00 when nothing is held
  always_comb begin
    io_rd = 8'h00;
    if (io_off == 16'h0000) begin
      io_rd = rx_full ? rx_byte : 8'h00;
    end else if (io_off == 16'h0004) begin
      io_rd = {5'b0, overflow, rx_full, io_buffer_full};
    end
  end

  assign rd_byte = is_io ? io_rd : ram[ram_idx];

  // RAM write port (contents are never reset)
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
  end

  // TX FIFO storage write at the tail slot
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[tail] <= mem_dout;
  end

  // RX holding byte capture; validity is tracked separately by rx_full
  always_ff @(posedge clk_in) begin
    if (rx_valid) rx_byte <= rx_data;
  end

  // Registered read data; holds while the bus is stalled or writing
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din <= 8'h00;
    end else if (rd_en) begin
      mem_din <= rd_byte;
    end
  end

  // FIFO pointers, RX flag, throttle, sticky overflow and halt strobe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
      rx_full        <= 1'b0;
      overflow       <= 1'b0;
      halt_out       <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (tx_pop)  head <= head + PTR_W'(1);
      count          <= count_next;
      io_buffer_full <= (count_next >= CNT_W'(TX_DEPTH - FULL_MARGIN));
      if (rx_valid) begin
        rx_full <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end
      if (push_drop || rx_overrun) overflow <= 1'b1;
      halt_out <= halt_req;
    end
  end

endmodule
